// File: rtl/mpei_multi_timer.sv
// Multi-channel APB timer: one shared prescaler feeding CHANNELS down-counters
// with periodic/one-shot mode, chaining, sticky W1C interrupts and debug halt.
module mpei_multi_timer #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [7:0]          paddr_i,
    input  logic [31:0]         pwdata_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    input  logic                dhalt_i,
    output logic [CHANNELS-1:0] tick_o,
    output logic [CHANNELS-1:0] irq_o
);

    logic                   wr;
    logic                   ptick;
    logic                   unused_addr;

    logic [PRESC_WIDTH-1:0] preload_q, preload_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;

    logic [WIDTH-1:0]       count_q  [CHANNELS];
    logic [WIDTH-1:0]       count_d  [CHANNELS];
    logic [WIDTH-1:0]       reload_q [CHANNELS];
    logic [WIDTH-1:0]       reload_d [CHANNELS];

    logic [CHANNELS-1:0]    en_q, en_d;
    logic [CHANNELS-1:0]    periodic_q, periodic_d;
    logic [CHANNELS-1:0]    irqen_q, irqen_d;
    logic [CHANNELS-1:0]    chain_q, chain_d;
    logic [CHANNELS-1:0]    pending_q, pending_d;
    logic [CHANNELS-1:0]    tick_q, tick_d;

    logic [CHANNELS-1:0]    step;
    logic [CHANNELS-1:0]    wr_count, wr_reload, wr_ctrl, wr_status;

    assign unused_addr = ^paddr_i[1:0];

    assign wr       = psel_i & penable_i & pwrite_i;
    assign ptick    = (presc_q == '0) & ~dhalt_i;
    assign pready_o = 1'b1;
    assign tick_o   = tick_q & {CHANNELS{~dhalt_i}};
    assign irq_o    = pending_q & irqen_q;

    // A PRELOAD write also restarts the prescaler from the new value.
    always_comb begin
        preload_d = preload_q;
        presc_d   = presc_q;
        if (!dhalt_i) begin
            presc_d = (presc_q == '0) ? preload_q : presc_q - PRESC_WIDTH'(1);
        end
        if (wr && paddr_i[7:2] == 6'd0) begin
            preload_d = pwdata_i[PRESC_WIDTH-1:0];
            presc_d   = pwdata_i[PRESC_WIDTH-1:0];
        end
    end

    // Update order sets priority: W1C clear, then underflow set, then SW writes.
    always_comb begin
        count_d    = count_q;
        reload_d   = reload_q;
        en_d       = en_q;
        periodic_d = periodic_q;
        irqen_d    = irqen_q;
        chain_d    = chain_q;
        pending_d  = pending_q;
        tick_d     = '0;
        step       = '0;
        wr_count   = '0;
        wr_reload  = '0;
        wr_ctrl    = '0;
        wr_status  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr && paddr_i[7:4] == 4'(c + 1)) begin
                wr_count[c]  = (paddr_i[3:2] == 2'd0);
                wr_reload[c] = (paddr_i[3:2] == 2'd1);
                wr_ctrl[c]   = (paddr_i[3:2] == 2'd2);
                wr_status[c] = (paddr_i[3:2] == 2'd3);
            end
            step[c] = en_q[c] && !dhalt_i &&
                      ((chain_q[c] && c != 0) ? tick_q[(c == 0) ? 0 : c - 1] : ptick);

            if (wr_status[c] && pwdata_i[0]) begin
                pending_d[c] = 1'b0;
            end
            if (step[c] && !wr_count[c]) begin
                if (count_q[c] == '0) begin
                    count_d[c]   = reload_q[c];
                    tick_d[c]    = 1'b1;
                    pending_d[c] = 1'b1;
                    if (!periodic_q[c]) begin
                        en_d[c] = 1'b0;
                    end
                end else begin
                    count_d[c] = count_q[c] - WIDTH'(1);
                end
            end
            if (wr_count[c]) begin
                count_d[c] = pwdata_i[WIDTH-1:0];
            end
            if (wr_reload[c]) begin
                reload_d[c] = pwdata_i[WIDTH-1:0];
            end
            if (wr_ctrl[c]) begin
                en_d[c]       = pwdata_i[0];
                periodic_d[c] = pwdata_i[1];
                irqen_d[c]    = pwdata_i[2];
                chain_d[c]    = pwdata_i[3];
            end
        end
    end

    always_comb begin
        prdata_o = '0;
        if (psel_i && !pwrite_i) begin
            if (paddr_i[7:2] == 6'd0) begin
                prdata_o = 32'(preload_q);
            end else if (paddr_i[7:2] == 6'd1) begin
                prdata_o = 32'(presc_q);
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (paddr_i[7:4] == 4'(c + 1)) begin
                    case (paddr_i[3:2])
                        2'd0:    prdata_o = 32'(count_q[c]);
                        2'd1:    prdata_o = 32'(reload_q[c]);
                        2'd2:    prdata_o = {28'd0, chain_q[c], irqen_q[c], periodic_q[c], en_q[c]};
                        default: prdata_o = {31'd0, pending_q[c]};
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            preload_q  <= '0;
            presc_q    <= '0;
            en_q       <= '0;
            periodic_q <= '0;
            irqen_q    <= '0;
            chain_q    <= '0;
            pending_q  <= '0;
            tick_q     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]  <= '0;
                reload_q[c] <= '0;
            end
        end else begin
            preload_q  <= preload_d;
            presc_q    <= presc_d;
            en_q       <= en_d;
            periodic_q <= periodic_d;
            irqen_q    <= irqen_d;
            chain_q    <= chain_d;
            pending_q  <= pending_d;
            tick_q     <= tick_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
        end
    end

endmodule

// File: tb/tb_mpei_multi_timer.sv
// Directed bench for mpei_multi_timer: reset, periodic, one-shot, chaining,
// same-cycle collisions and debug halt, with hand-computed expectations.
module tb_mpei_multi_timer;

    localparam int CH = 4;
    localparam logic [7:0] A_PRELOAD = 8'h00;
    localparam logic [7:0] A_PRESC   = 8'h04;
    localparam int O_COUNT  = 0;
    localparam int O_RELOAD = 4;
    localparam int O_CTRL   = 8;
    localparam int O_STATUS = 12;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          psel_i, penable_i, pwrite_i, dhalt_i;
    logic [7:0]    paddr_i;
    logic [31:0]   pwdata_i, prdata_o;
    logic          pready_o;
    logic [CH-1:0] tick_o, irq_o;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk_i = ~clk_i;

    mpei_multi_timer #(.CHANNELS(CH), .WIDTH(32), .PRESC_WIDTH(16)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwrite_i  (pwrite_i),
        .paddr_i   (paddr_i),
        .pwdata_i  (pwdata_i),
        .prdata_o  (prdata_o),
        .pready_o  (pready_o),
        .dhalt_i   (dhalt_i),
        .tick_o    (tick_o),
        .irq_o     (irq_o)
    );

    function automatic logic [7:0] ch_addr(input int ch, input int off);
        return 8'(16 + 16 * ch + off);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Commit lands on the second posedge after the call; returns on the following negedge.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
        @(negedge clk_i);
        penable_i = 1'b1;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
        #1;
        d = prdata_o;
        psel_i = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check_val(tag, d, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tt[3];
        int nt, n0, n1, first1, bad_chain, seen;
        logic prev0;

        rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        dhalt_i = 1'b0; paddr_i = '0; pwdata_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // Reset mid-count
        apb_write(A_PRELOAD, 3);
        apb_write(ch_addr(0, O_COUNT), 5);
        apb_write(ch_addr(0, O_CTRL), 1);
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check_val("t1_tick", tick_o, 0);
        check_val("t1_irq", irq_o, 0);
        check_reg("t1_count0", ch_addr(0, O_COUNT), 0);
        check_reg("t1_presc", A_PRESC, 0);
        for (int a = 0; a < 8'h50; a += 4) begin
            check_reg("t1_rd_zero", 8'(a), 0);
        end
        @(negedge clk_i);
        check_val("t1_tick_after", tick_o, 0);
        check_val("t1_pready", pready_o, 1);

        // Periodic: 4 steps of 2 cycles each
        apb_write(A_PRELOAD, 1);
        apb_write(ch_addr(0, O_RELOAD), 3);
        apb_write(ch_addr(0, O_COUNT), 3);
        apb_write(ch_addr(0, O_CTRL), 7);
        check_val("t2_irq_pre", irq_o[0], 0);
        nt = 0;
        for (int i = 0; i < 40 && nt < 3; i++) begin
            @(negedge clk_i);
            if (tick_o[0]) begin
                tt[nt] = i;
                nt++;
            end
        end
        check_val("t2_ticks", nt, 3);
        check_val("t2_first_window", (tt[0] >= 5 && tt[0] <= 7), 1);
        check_val("t2_period_a", tt[1] - tt[0], 8);
        check_val("t2_period_b", tt[2] - tt[1], 8);
        check_val("t2_irq_set", irq_o[0], 1);
        apb_write(ch_addr(0, O_STATUS), 1);
        check_val("t2_irq_w1c", irq_o[0], 0);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk_i);
            if (tick_o[0]) seen = 1;
        end
        check_val("t2_tick_again", seen, 1);
        apb_write(ch_addr(0, O_CTRL), 2);
        check_val("t2_irq_masked", irq_o[0], 0);
        check_reg("t2_pending_kept", ch_addr(0, O_STATUS), 1);
        apb_write(ch_addr(0, O_STATUS), 1);
        check_reg("t2_pending_clr", ch_addr(0, O_STATUS), 0);

        // One-shot on channel 1, prescaler every cycle
        apb_write(A_PRELOAD, 0);
        apb_write(ch_addr(1, O_RELOAD), 7);
        apb_write(ch_addr(1, O_COUNT), 2);
        apb_write(ch_addr(1, O_CTRL), 5);
        nt = 0; tt[0] = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (tick_o[1]) begin
                if (nt == 0) tt[0] = i;
                nt++;
            end
        end
        check_val("t3_tick_count", nt, 1);
        check_val("t3_tick_at", tt[0], 2);
        check_reg("t3_ctrl", ch_addr(1, O_CTRL), 4);
        check_reg("t3_count", ch_addr(1, O_COUNT), 7);
        check_val("t3_irq", irq_o[1], 1);
        apb_write(ch_addr(1, O_STATUS), 1);
        apb_write(ch_addr(1, O_CTRL), 0);

        // Chaining: ch1 steps on ch0 ticks
        apb_write(ch_addr(0, O_RELOAD), 1);
        apb_write(ch_addr(0, O_COUNT), 1);
        apb_write(ch_addr(1, O_RELOAD), 2);
        apb_write(ch_addr(1, O_COUNT), 2);
        apb_write(ch_addr(1, O_CTRL), 32'hB);
        apb_write(ch_addr(0, O_CTRL), 3);
        n0 = 0; n1 = 0; first1 = -1; bad_chain = 0; prev0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (tick_o[0]) n0++;
            if (tick_o[1]) begin
                if (first1 < 0) first1 = i;
                n1++;
                if (!prev0) bad_chain++;
            end
            prev0 = tick_o[0];
        end
        check_val("t4_tick0_count", n0, 20);
        check_val("t4_tick1_count", n1, 6);
        check_val("t4_tick1_first", first1, 6);
        check_val("t4_tick1_after_tick0", bad_chain, 0);
        apb_write(ch_addr(0, O_CTRL), 0);
        apb_write(ch_addr(1, O_CTRL), 0);
        apb_write(ch_addr(0, O_STATUS), 1);
        apb_write(ch_addr(1, O_STATUS), 1);

        // Collision: W1C in the underflow cycle, set wins
        apb_write(ch_addr(2, O_RELOAD), 4);
        apb_write(ch_addr(2, O_COUNT), 2);
        apb_write(ch_addr(2, O_CTRL), 5);
        apb_write(ch_addr(2, O_STATUS), 1);
        check_val("t5_w1c_tick", tick_o[2], 1);
        check_val("t5_w1c_irq", irq_o[2], 1);
        check_reg("t5_w1c_pending", ch_addr(2, O_STATUS), 1);
        apb_write(ch_addr(2, O_STATUS), 1);
        check_reg("t5_pending_clr", ch_addr(2, O_STATUS), 0);

        // Collision: COUNT write in the underflow cycle, write wins
        apb_write(ch_addr(2, O_COUNT), 2);
        apb_write(ch_addr(2, O_CTRL), 5);
        apb_write(ch_addr(2, O_COUNT), 9);
        check_val("t5_cnt_tick", tick_o[2], 0);
        check_reg("t5_cnt_value", ch_addr(2, O_COUNT), 9);
        check_reg("t5_cnt_pending", ch_addr(2, O_STATUS), 0);
        @(negedge clk_i);
        check_val("t5_cnt_tick_next", tick_o[2], 0);
        apb_write(ch_addr(2, O_CTRL), 0);

        // Collision: CTRL write keeping en=1 at a one-shot underflow, write wins
        apb_write(ch_addr(3, O_RELOAD), 4);
        apb_write(ch_addr(3, O_COUNT), 2);
        apb_write(ch_addr(3, O_CTRL), 1);
        apb_write(ch_addr(3, O_CTRL), 1);
        check_val("t5_ctrl_tick", tick_o[3], 1);
        check_reg("t5_ctrl_en_kept", ch_addr(3, O_CTRL), 1);
        apb_write(ch_addr(3, O_CTRL), 0);
        apb_write(ch_addr(3, O_STATUS), 1);

        // Debug halt: PRELOAD=9, COUNT=50, halt 15 cycles after enable
        apb_write(A_PRELOAD, 9);
        apb_write(ch_addr(0, O_RELOAD), 50);
        apb_write(ch_addr(0, O_COUNT), 50);
        apb_write(ch_addr(0, O_CTRL), 3);
        repeat (15) @(negedge clk_i);
        dhalt_i = 1'b1;
        check_reg("t6_presc_halt", A_PRESC, 5);
        check_reg("t6_count_halt", ch_addr(0, O_COUNT), 48);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (tick_o != '0) seen++;
        end
        check_val("t6_no_tick", seen, 0);
        check_reg("t6_presc_frozen", A_PRESC, 5);
        check_reg("t6_count_frozen", ch_addr(0, O_COUNT), 48);
        dhalt_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check_reg("t6_presc_resume", A_PRESC, 9);
        check_reg("t6_count_resume", ch_addr(0, O_COUNT), 47);
        apb_write(ch_addr(0, O_CTRL), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
